// File: rtl/servile_ext_pkg.sv
// Shared types and constants for the Servile extension-port bridge.
// Optional read watchdog is enabled with SERVILE_EXT_TIMEOUT_EN.
package servile_ext_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ACK
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/servile_ext_wdt.sv
// Read watchdog: counts cycles while enabled, flags the cycle that
// brings the count up to LIMIT. Used only with SERVILE_EXT_TIMEOUT_EN.
module servile_ext_wdt #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en && cnt != W'(LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign o_expired = i_en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/servile_ext_bridge.sv
// Wishbone slave on Servile's ext port -> pulsed peripheral bus.
// Define SERVILE_EXT_TIMEOUT_EN to close hung reads with ERR_DATA.
module servile_ext_bridge
  import servile_ext_pkg::*;
#(
  parameter int          AW       = 16,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic [AW-1:0] o_per_adr,
  output logic [31:0]   o_per_wdat,
  output logic [3:0]    o_per_be,
  output logic          o_per_we,
  output logic          o_per_re,
  input  logic [31:0]   i_per_rdat,
  input  logic          i_per_rvalid,
  output logic          o_err
);

  state_t state;
  logic   we_q;

`ifdef SERVILE_EXT_TIMEOUT_EN
  logic wdt_clr;
  logic wdt_en;
  logic wdt_expired;

  assign wdt_clr = (state == IDLE) && i_wb_stb;
  assign wdt_en  = (state == REQ) || (state == WAIT);

  servile_ext_wdt #(
    .LIMIT (TIMEOUT),
    .W     (cnt_width(TIMEOUT))
  ) u_wdt (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (wdt_clr),
    .i_en      (wdt_en),
    .o_expired (wdt_expired)
  );

  logic unused_bits;
  assign unused_bits = &{1'b0, i_wb_adr[31:AW]};
`else
  assign o_err = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, i_wb_adr[31:AW], ERR_DATA, TIMEOUT};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      o_wb_rdt   <= '0;
      o_wb_ack   <= 1'b0;
      o_per_adr  <= '0;
      o_per_wdat <= '0;
      o_per_be   <= '0;
      o_per_we   <= 1'b0;
      o_per_re   <= 1'b0;
`ifdef SERVILE_EXT_TIMEOUT_EN
      o_err      <= 1'b0;
`endif
    end else begin
      o_per_we <= 1'b0;
      o_per_re <= 1'b0;
      o_wb_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_wb_stb) begin
            we_q       <= i_wb_we;
            o_per_adr  <= i_wb_adr[AW-1:0];
            o_per_wdat <= i_wb_dat;
            o_per_be   <= i_wb_sel;
            o_per_we   <= i_wb_we;
            o_per_re   <= !i_wb_we;
            state      <= REQ;
          end
        end
        // Writes complete in REQ; reads wait for rvalid or the watchdog.
        REQ, WAIT: begin
          if (we_q) begin
            o_wb_ack <= 1'b1;
            state    <= ACK;
          end else if (i_per_rvalid) begin
            o_wb_rdt <= i_per_rdat;
            o_wb_ack <= 1'b1;
            state    <= ACK;
`ifdef SERVILE_EXT_TIMEOUT_EN
          end else if (wdt_expired) begin
            o_wb_rdt <= ERR_DATA;
            o_wb_ack <= 1'b1;
            o_err    <= 1'b1;
            state    <= ACK;
`endif
          end else begin
            state <= WAIT;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servile_ext_bridge.sv
// Directed + random bench for servile_ext_bridge with an expected-ack queue.
// Build with SERVILE_EXT_TIMEOUT_EN to exercise the watchdog (TIMEOUT=8).
module tb_servile_ext_bridge;

`ifdef SERVILE_EXT_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [15:0] o_per_adr;
  logic [31:0] o_per_wdat;
  logic [3:0]  o_per_be;
  logic        o_per_we;
  logic        o_per_re;
  logic [31:0] i_per_rdat;
  logic        i_per_rvalid;
  logic        o_err;

  servile_ext_bridge #(
    .AW       (16),
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_wb_adr     (i_wb_adr),
    .i_wb_dat     (i_wb_dat),
    .i_wb_sel     (i_wb_sel),
    .i_wb_we      (i_wb_we),
    .i_wb_stb     (i_wb_stb),
    .o_wb_rdt     (o_wb_rdt),
    .o_wb_ack     (o_wb_ack),
    .o_per_adr    (o_per_adr),
    .o_per_wdat   (o_per_wdat),
    .o_per_be     (o_per_be),
    .o_per_we     (o_per_we),
    .o_per_re     (o_per_re),
    .i_per_rdat   (i_per_rdat),
    .i_per_rvalid (i_per_rvalid),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          exp_lat_q[$];
  logic [31:0] exp_rdt_q[$];
  logic [31:0] model_rdt;
  logic        model_err;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_wb_stb     = 1'b0;
      i_per_rvalid = 1'b0;
      chk("idle_ack", {31'd0, o_wb_ack}, 32'd0);
    end
  endtask

  // d = cycles after the o_per_re cycle before rvalid; d<0 means never
  task automatic access(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input int d, input logic [31:0] rdat);
    int          lat;
    int          c;
    int          nwe;
    int          nre;
    bit          got;
    logic [31:0] erdt;
    if (we) begin
      lat  = 2;
      erdt = model_rdt;
    end else begin
      lat  = d + 2;
      erdt = rdat;
`ifdef SERVILE_EXT_TIMEOUT_EN
      if (d < 0 || d >= TO) begin
        lat       = TO + 1;
        erdt      = 32'hDEAD_BEEF;
        model_err = 1'b1;
      end
`endif
      model_rdt = erdt;
    end
    exp_lat_q.push_back(lat);
    exp_rdt_q.push_back(erdt);

    @(posedge clk); #1;
    chk("ack_single", {31'd0, o_wb_ack}, 32'd0);
    i_wb_stb     = 1'b1;
    i_wb_we      = we;
    i_wb_adr     = adr;
    i_wb_dat     = dat;
    i_wb_sel     = sel;
    i_per_rvalid = 1'b0;

    @(posedge clk); #1;
    c   = 1;
    nwe = 0;
    nre = 0;
    got = 0;
    chk("per_adr", {16'd0, o_per_adr}, {16'd0, adr[15:0]});
    chk("per_be", {28'd0, o_per_be}, {28'd0, sel});
    chk("per_wdat", o_per_wdat, dat);
    while (!got && c <= lat + 4) begin
      nwe += int'(o_per_we);
      nre += int'(o_per_re);
      if (o_wb_ack) begin
        got = 1;
      end else begin
        i_per_rvalid = !we && (c == d + 1);
        i_per_rdat   = i_per_rvalid ? rdat : $urandom;
        @(posedge clk); #1;
        c++;
      end
    end
    i_per_rvalid = 1'b0;

    lat  = exp_lat_q.pop_front();
    erdt = exp_rdt_q.pop_front();
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL ack_missing observed=none expected=ack_at_%0d", lat);
    end
    if (got) begin
      chk("ack_latency", c, lat);
      chk("wb_rdt", o_wb_rdt, erdt);
      chk("err_flag", {31'd0, o_err}, {31'd0, model_err});
    end
    chk("we_pulses", nwe, we ? 32'd1 : 32'd0);
    chk("re_pulses", nre, we ? 32'd0 : 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    i_wb_adr     = '0;
    i_wb_dat     = '0;
    i_wb_sel     = '0;
    i_wb_we      = 1'b0;
    i_wb_stb     = 1'b0;
    i_per_rdat   = '0;
    i_per_rvalid = 1'b0;
    model_rdt    = '0;
    model_err    = 1'b0;

    #12;
    chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("rst_rdt", o_wb_rdt, 32'd0);
    chk("rst_adr", {16'd0, o_per_adr}, 32'd0);
    chk("rst_pulse", {30'd0, o_per_we, o_per_re}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    access(1'b1, 32'h4000_0010, 32'h1234_5678, 4'b0011, 0, 32'h0);
    idle(2);
    access(1'b0, 32'h4000_0020, 32'h0, 4'hF, 0, 32'hCAFE_F00D);
    access(1'b0, 32'h4000_0024, 32'h0, 4'hF, 5, 32'h1111_2222);
    access(1'b1, 32'h4000_0028, 32'hA5A5_5A5A, 4'b1100, 0, 32'h0);

    for (int i = 0; i < 100; i++) begin
      access(1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), $urandom);
    end

    // Async reset while a read sits in WAIT
    access(1'b0, 32'h4000_0030, 32'h0, 4'hF, 1, 32'h7777_8888);
    @(posedge clk); #1;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    i_wb_adr = 32'h4000_0F0C;
    i_wb_dat = 32'h3C3C_3C3C;
    i_wb_sel = 4'hF;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("arst_rdt", o_wb_rdt, 32'd0);
    chk("arst_adr", {16'd0, o_per_adr}, 32'd0);
    chk("arst_wdat", o_per_wdat, 32'd0);
    chk("arst_be", {28'd0, o_per_be}, 32'd0);
    i_wb_stb = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("arst_hold_ack", {31'd0, o_wb_ack}, 32'd0);
    end
    rst_n     = 1'b1;
    model_rdt = '0;
    model_err = 1'b0;
    idle(1);
    access(1'b0, 32'h4000_0040, 32'h0, 4'hF, 2, 32'h0BAD_CAFE);
    idle(1);

`ifdef SERVILE_EXT_TIMEOUT_EN
    access(1'b0, 32'h4000_0050, 32'h0, 4'hF, -1, 32'h0);
    idle(2);
    @(posedge clk); #1;
    i_per_rvalid = 1'b1;
    i_per_rdat   = 32'h5555_AAAA;
    @(posedge clk); #1;
    i_per_rvalid = 1'b0;
    chk("late_rvalid_ack", {31'd0, o_wb_ack}, 32'd0);
    chk("late_rvalid_rdt", o_wb_rdt, 32'hDEAD_BEEF);
    chk("err_sticky", {31'd0, o_err}, 32'd1);
    idle(1);
    access(1'b0, 32'h4000_0054, 32'h0, 4'hF, 3, 32'h600D_DA7A);
    access(1'b1, 32'h4000_0058, 32'h1, 4'hF, 0, 32'h0);
`else
    access(1'b0, 32'h4000_0060, 32'h0, 4'hF, 1000, 32'h0123_4567);
    idle(3);
    chk("no_err", {31'd0, o_err}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
